// File: rtl/load_store_unit.sv
// Memory stage of the RV32I pipeline: issues load/store accesses over a req/ack bus,
// aligns and extends load data, passes ALU results through and latches a sticky fault.
module load_store_unit #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic [4:0]  rd_addr_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] store_data_in,
  input  logic        load_en,
  input  logic        store_en,
  input  logic [1:0]  size_in,
  input  logic        unsigned_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        valid_out,
  output logic [4:0]  rd_addr_out,
  output logic [31:0] rd_out,
  output logic        writeback_en_out,
  output logic        fault
);

  typedef enum logic [1:0] {StIdle, StBusy, StFault} state_e;

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d, uns_q, uns_d;
  logic [1:0]  size_q, size_d, off_q, off_d;
  logic [4:0]  pend_rd_q, pend_rd_d;
  logic        valid_out_q, valid_out_d, wb_q, wb_d;
  logic [4:0]  rd_addr_out_q, rd_addr_out_d;
  logic [31:0] rd_out_q, rd_out_d;

  logic        illegal;
  logic [3:0]  be_acc;
  logic [31:0] wdata_acc;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;

  always_comb begin
    illegal = (load_en && store_en) || (size_in == 2'b11) ||
              (size_in == 2'b01 && alu_in[0]) || (size_in == 2'b10 && alu_in[1:0] != 2'b00);
    be_acc    = 4'b0000;
    wdata_acc = store_data_in;
    unique case (size_in)
      2'b00: begin
        be_acc    = 4'b0001 << alu_in[1:0];
        wdata_acc = {4{store_data_in[7:0]}};
      end
      2'b01: begin
        be_acc    = alu_in[1] ? 4'b1100 : 4'b0011;
        wdata_acc = {2{store_data_in[15:0]}};
      end
      2'b10:   be_acc = 4'b1111;
      default: be_acc = 4'b0000;
    endcase
  end

  // Lane select and extension of the returned read data.
  always_comb begin
    unique case (off_q)
      2'b00:   lane_b = mem_rdata[7:0];
      2'b01:   lane_b = mem_rdata[15:8];
      2'b10:   lane_b = mem_rdata[23:16];
      default: lane_b = mem_rdata[31:24];
    endcase
    lane_h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (size_q)
      2'b00:   load_val = uns_q ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   load_val = uns_q ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_val = mem_rdata;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    be_d          = be_q;
    we_d          = we_q;
    uns_d         = uns_q;
    size_d        = size_q;
    off_d         = off_q;
    pend_rd_d     = pend_rd_q;
    valid_out_d   = 1'b0;
    rd_addr_out_d = rd_addr_out_q;
    rd_out_d      = rd_out_q;
    wb_d          = wb_q;
    unique case (state_q)
      StIdle: begin
        if (valid_in) begin
          if (!load_en && !store_en) begin
            valid_out_d   = 1'b1;
            rd_out_d      = alu_in;
            rd_addr_out_d = rd_addr_in;
            wb_d          = (rd_addr_in != 5'd0);
          end else if (illegal) begin
            state_d = StFault;
          end else begin
            state_d   = StBusy;
            wait_d    = 8'd0;
            addr_d    = {alu_in[31:2], 2'b00};
            we_d      = store_en;
            be_d      = be_acc;
            wdata_d   = store_en ? wdata_acc : 32'd0;
            size_d    = size_in;
            off_d     = alu_in[1:0];
            uns_d     = unsigned_in;
            pend_rd_d = rd_addr_in;
          end
        end
      end
      StBusy: begin
        if (mem_ack) begin
          state_d       = StIdle;
          valid_out_d   = 1'b1;
          rd_addr_out_d = pend_rd_q;
          rd_out_d      = we_q ? 32'd0 : load_val;
          wb_d          = !we_q && (pend_rd_q != 5'd0);
        end else if (wait_q == 8'(MAX_WAIT - 1)) begin
          state_d = StFault;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StFault: state_d = StFault;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      wait_q        <= 8'd0;
      addr_q        <= 32'd0;
      wdata_q       <= 32'd0;
      be_q          <= 4'd0;
      we_q          <= 1'b0;
      uns_q         <= 1'b0;
      size_q        <= 2'd0;
      off_q         <= 2'd0;
      pend_rd_q     <= 5'd0;
      valid_out_q   <= 1'b0;
      rd_addr_out_q <= 5'd0;
      rd_out_q      <= 32'd0;
      wb_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      be_q          <= be_d;
      we_q          <= we_d;
      uns_q         <= uns_d;
      size_q        <= size_d;
      off_q         <= off_d;
      pend_rd_q     <= pend_rd_d;
      valid_out_q   <= valid_out_d;
      rd_addr_out_q <= rd_addr_out_d;
      rd_out_q      <= rd_out_d;
      wb_q          <= wb_d;
    end
  end

  // Bus request follows the state so an async reset drops it immediately.
  assign mem_req          = (state_q == StBusy);
  assign ready_out        = (state_q == StIdle);
  assign fault            = (state_q == StFault);
  assign mem_we           = we_q;
  assign mem_addr         = addr_q;
  assign mem_wdata        = wdata_q;
  assign mem_be           = be_q;
  assign valid_out        = valid_out_q;
  assign rd_addr_out      = rd_addr_out_q;
  assign rd_out           = rd_out_q;
  assign writeback_en_out = wb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit with MAX_WAIT = 4.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic [4:0]  rd_addr_in = '0;
  logic [31:0] alu_in = '0;
  logic [31:0] store_data_in = '0;
  logic        load_en = 1'b0;
  logic        store_en = 1'b0;
  logic [1:0]  size_in = '0;
  logic        unsigned_in = 1'b0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        valid_out;
  logic [4:0]  rd_addr_out;
  logic [31:0] rd_out;
  logic        writeback_en_out;
  logic        fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out),
    .rd_addr_in(rd_addr_in), .alu_in(alu_in), .store_data_in(store_data_in),
    .load_en(load_en), .store_en(store_en), .size_in(size_in), .unsigned_in(unsigned_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .valid_out(valid_out),
    .rd_addr_out(rd_addr_out), .rd_out(rd_out), .writeback_en_out(writeback_en_out),
    .fault(fault)
  );

  typedef struct {
    logic        ld;
    logic        st;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] alu;
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          dly;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rd;
    logic        e_wb;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    valid_in = 1'b0;
    mem_ack = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic drive(input logic ld, input logic st, input logic [1:0] sz, input logic un,
                       input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd);
    valid_in = 1'b1;
    load_en = ld;
    store_en = st;
    size_in = sz;
    unsigned_in = un;
    alu_in = alu;
    store_data_in = sd;
    rd_addr_in = rd;
  endtask

  task automatic do_op(input vec_t v);
    drive(v.ld, v.st, v.size, v.uns, v.alu, v.sdata, v.rd);
    tick();
    valid_in = 1'b0;
    if (v.ld || v.st) begin
      chk("req", 32'(mem_req), 32'd1);
      chk("ready_busy", 32'(ready_out), 32'd0);
      chk("addr", mem_addr, v.e_addr);
      chk("be", 32'(mem_be), 32'(v.e_be));
      chk("wdata", mem_wdata, v.e_wdata);
      chk("we", 32'(mem_we), 32'(v.st));
      for (int i = 1; i < v.dly; i++) tick();
      mem_rdata = v.rdata;
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      mem_rdata = 32'h0;
      chk("req_drop", 32'(mem_req), 32'd0);
      chk("ready_back", 32'(ready_out), 32'd1);
    end
    chk("valid_out", 32'(valid_out), 32'd1);
    chk("rd_out", rd_out, v.e_rd);
    chk("rd_addr_out", 32'(rd_addr_out), 32'(v.rd));
    chk("wb_en", 32'(writeback_en_out), 32'(v.e_wb));
    tick();
    chk("valid_low", 32'(valid_out), 32'd0);
  endtask

  task automatic illegal_case(input string name, input logic ld, input logic st,
                              input logic [1:0] sz, input logic [31:0] alu);
    do_reset();
    drive(ld, st, sz, 1'b0, alu, 32'h1234_5678, 5'd9);
    tick();
    valid_in = 1'b0;
    chk({name, "_fault"}, 32'(fault), 32'd1);
    chk({name, "_req"}, 32'(mem_req), 32'd0);
    chk({name, "_ready"}, 32'(ready_out), 32'd0);
    tick();
    chk({name, "_req2"}, 32'(mem_req), 32'd0);
    chk({name, "_valid"}, 32'(valid_out), 32'd0);
  endtask

  initial begin
    //          ld    st    size   uns   alu           sdata         rd    rdata         dly
    //          e_addr        e_be     e_wdata       e_rd          e_wb
    vecs[0] = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h103, 32'hAABBCCDD, 5'd7, 32'h0, 3,
                32'h100, 4'b1000, 32'hDDDDDDDD, 32'h0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 5'd3, 32'h80010000, 1,
                32'h200, 4'b1100, 32'h0, 32'hFFFF8001, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h202, 32'h0, 5'd3, 32'h80010000, 1,
                32'h200, 4'b1100, 32'h0, 32'h00008001, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h303, 32'h0, 5'd4, 32'h7F000000, 2,
                32'h300, 4'b1000, 32'h0, 32'h0000007F, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h41, 32'h0, 5'd6, 32'h00008000, 1,
                32'h40, 4'b0010, 32'h0, 32'hFFFFFF80, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h52, 32'h12345678, 5'd1, 32'h0, 1,
                32'h50, 4'b1100, 32'h56785678, 32'h0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h60, 32'hCAFEBABE, 5'd2, 32'h0, 2,
                32'h60, 4'b1111, 32'hCAFEBABE, 32'h0, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h74, 32'h0, 5'd0, 32'h89ABCDEF, 4,
                32'h74, 4'b1111, 32'h0, 32'h89ABCDEF, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 2'b00, 1'b0, 32'h1234, 32'h0, 5'd5, 32'h0, 0,
                32'h0, 4'b0000, 32'h0, 32'h1234, 1'b1};
    vecs[9] = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h80, 32'h000000A5, 5'd8, 32'h0, 1,
                32'h80, 4'b0001, 32'hA5A5A5A5, 32'h0, 1'b0};

    // Reset state
    #2;
    chk("rst_ready", 32'(ready_out), 32'd1);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_rd_out", rd_out, 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    rst = 1'b1;
    tick();

    foreach (vecs[i]) do_op(vecs[i]);

    // Back-to-back pass-through, then with rd = 0
    for (int pass = 0; pass < 2; pass++) begin
      drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_1234, 32'h0, (pass == 0) ? 5'd5 : 5'd0);
      for (int c = 0; c < 3; c++) begin
        tick();
        if (c == 2) valid_in = 1'b0;
        chk("b2b_valid", 32'(valid_out), 32'd1);
        chk("b2b_rd", rd_out, 32'h1234);
        chk("b2b_wb", 32'(writeback_en_out), (pass == 0) ? 32'd1 : 32'd0);
        chk("b2b_ready", 32'(ready_out), 32'd1);
      end
      tick();
      chk("b2b_end", 32'(valid_out), 32'd0);
    end

    illegal_case("misaligned_word", 1'b1, 1'b0, 2'b10, 32'h101);
    illegal_case("size11", 1'b1, 1'b0, 2'b11, 32'h100);
    illegal_case("ld_and_st", 1'b1, 1'b1, 2'b10, 32'h100);
    illegal_case("misaligned_half", 1'b0, 1'b1, 2'b01, 32'h203);

    // Timeout: MAX_WAIT = 4, no ack
    begin
      int cnt;
      do_reset();
      drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd3);
      tick();
      valid_in = 1'b0;
      cnt = 0;
      while (mem_req && cnt < 20) begin
        cnt++;
        tick();
      end
      chk("timeout_req_cycles", 32'(cnt), 32'd4);
      chk("timeout_fault", 32'(fault), 32'd1);
      chk("timeout_ready", 32'(ready_out), 32'd0);
      mem_ack = 1'b1;
      mem_rdata = 32'hFFFF_FFFF;
      tick();
      mem_ack = 1'b0;
      chk("late_ack_valid", 32'(valid_out), 32'd0);
      chk("late_ack_fault", 32'(fault), 32'd1);
      chk("late_ack_req", 32'(mem_req), 32'd0);
    end

    // Async reset mid-access
    do_reset();
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 5'd10);
    tick();
    valid_in = 1'b0;
    chk("mid_req_before", 32'(mem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_req", 32'(mem_req), 32'd0);
    chk("mid_rst_fault", 32'(fault), 32'd0);
    chk("mid_rst_ready", 32'(ready_out), 32'd1);
    chk("mid_rst_addr", mem_addr, 32'd0);
    #1 rst = 1'b1;
    tick();
    chk("post_rst_valid", 32'(valid_out), 32'd0);
    do_op(vecs[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
